// File: rtl/lsu_arb_pkg.sv
// Shared definitions for the LSU data-port arbiter.
//   idx_width() : bits needed to index n items (never less than 1)
//   AtopWidth   : width of the atomic-opcode field
package lsu_arb_pkg;

   localparam int unsigned AtopWidth = 6;

   function automatic int unsigned idx_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/lsu_arb_id_fifo.sv
// Requester-ID FIFO: remembers which requester owns each outstanding
// memory transaction so in-order responses can be routed back.
//   clk_i, rst_ni : clock, async active-low reset
//   push_i/data_i : enqueue an ID (accepted when not full, or full with pop)
//   pop_i         : dequeue the head (ignored when empty)
//   head_o        : ID at the head of the queue
//   full_o/empty_o/usage_o : occupancy status
module lsu_arb_id_fifo
   import lsu_arb_pkg::*;
#(
   parameter int unsigned Depth = 4,
   parameter int unsigned Width = 2
) (
   input  logic                         clk_i,
   input  logic                         rst_ni,
   input  logic                         push_i,
   input  logic                         pop_i,
   input  logic [Width-1:0]             data_i,
   output logic [Width-1:0]             head_o,
   output logic                         full_o,
   output logic                         empty_o,
   output logic [$clog2(Depth+1)-1:0]   usage_o
);

   localparam int unsigned PtrW = idx_width(Depth);
   localparam int unsigned CntW = $clog2(Depth + 1);

   logic [Width-1:0] mem_q [Depth];
   logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CntW-1:0]  cnt_q, cnt_d;
   logic             push_ok, pop_ok;

   assign full_o  = (cnt_q == CntW'(Depth));
   assign empty_o = (cnt_q == '0);
   assign usage_o = cnt_q;
   assign head_o  = mem_q[rd_ptr_q];

   // A push into a full FIFO is fine when the head leaves in the same cycle.
   assign push_ok = push_i & (~full_o | pop_i);
   assign pop_ok  = pop_i & ~empty_o;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      cnt_d    = cnt_q;
      if (push_ok) wr_ptr_d = (wr_ptr_q == PtrW'(Depth - 1)) ? '0 : wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_d = (rd_ptr_q == PtrW'(Depth - 1)) ? '0 : rd_ptr_q + 1'b1;
      case ({push_ok, pop_ok})
         2'b10:   cnt_d = cnt_q + 1'b1;
         2'b01:   cnt_d = cnt_q - 1'b1;
         default: cnt_d = cnt_q;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
         for (int i = 0; i < int'(Depth); i++) mem_q[i] <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
         if (push_ok) mem_q[wr_ptr_q] <= data_i;
      end
   end

endmodule

// File: rtl/lsu_data_port_arbiter.sv
// Shares one data-memory port (req/gnt/rvalid) among NumReq LSUs.
// Round-robin selection with the choice locked while the memory stalls,
// and an ID FIFO that steers in-order responses back to their issuer.
//   req_i, addr_i, we_i, be_i, wdata_i, atop_i, buffer_i : per-LSU request
//   gnt_o, rvalid_o, err_o, rdata_o                       : per-LSU handshake/response
//   mem_*                                                 : shared memory master port
//   busy_o : transactions outstanding or a request is on the port
module lsu_data_port_arbiter
   import lsu_arb_pkg::*;
#(
   parameter int unsigned NumReq         = 4,
   parameter int unsigned MaxOutstanding = 4,
   parameter int unsigned AddrWidth      = 32,
   parameter int unsigned DataWidth      = 32
) (
   input  logic                                     clk_i,
   input  logic                                     rst_ni,
   input  logic [NumReq-1:0]                        req_i,
   input  logic [NumReq-1:0][AddrWidth-1:0]         addr_i,
   input  logic [NumReq-1:0]                        we_i,
   input  logic [NumReq-1:0][DataWidth/8-1:0]       be_i,
   input  logic [NumReq-1:0][DataWidth-1:0]         wdata_i,
   input  logic [NumReq-1:0][AtopWidth-1:0]         atop_i,
   input  logic [NumReq-1:0]                        buffer_i,
   output logic [NumReq-1:0]                        gnt_o,
   output logic [NumReq-1:0]                        rvalid_o,
   output logic [DataWidth-1:0]                     rdata_o,
   output logic [NumReq-1:0]                        err_o,
   output logic                                     mem_req_o,
   input  logic                                     mem_gnt_i,
   output logic [AddrWidth-1:0]                     mem_addr_o,
   output logic                                     mem_we_o,
   output logic [DataWidth/8-1:0]                   mem_be_o,
   output logic [DataWidth-1:0]                     mem_wdata_o,
   output logic [AtopWidth-1:0]                     mem_atop_o,
   output logic                                     mem_buffer_o,
   input  logic                                     mem_rvalid_i,
   input  logic [DataWidth-1:0]                     mem_rdata_i,
   input  logic                                     mem_err_i,
   output logic                                     busy_o
);

   localparam int unsigned IdxW = idx_width(NumReq);
   localparam int unsigned CntW = $clog2(MaxOutstanding + 1);

   logic [IdxW-1:0] prio_q, prio_d, sel, sel_rr, lock_idx_q, lock_idx_d, head;
   logic            lock_q, lock_d;
   logic            can_issue, hs, pop, fifo_full, fifo_empty;
   logic [CntW-1:0] usage;

   function automatic logic [IdxW-1:0] rr_pick(input logic [NumReq-1:0] req,
                                                input logic [IdxW-1:0]   prio);
      logic [IdxW-1:0] pick;
      int unsigned     j;
      logic            found;
      pick  = prio;
      found = 1'b0;
      for (int unsigned i = 0; i < NumReq; i++) begin
         j = 32'(prio) + i;
         if (j >= NumReq) j = j - NumReq;
         if (!found && req[j]) begin
            found = 1'b1;
            pick  = IdxW'(j);
         end
      end
      return pick;
   endfunction

   assign sel_rr = rr_pick(req_i, prio_q);
   // A stalled request keeps its requester so the memory sees stable fields.
   assign sel    = lock_q ? lock_idx_q : sel_rr;

   // A full FIFO can still issue when a response pops the head this cycle,
   // which keeps zero-latency memories at one transaction per cycle.
   assign can_issue = ~fifo_full | mem_rvalid_i;
   assign mem_req_o = req_i[sel] & can_issue;
   assign hs        = mem_req_o & mem_gnt_i;
   assign pop       = mem_rvalid_i & ~fifo_empty;

   assign mem_addr_o   = addr_i[sel];
   assign mem_we_o     = we_i[sel];
   assign mem_be_o     = be_i[sel];
   assign mem_wdata_o  = wdata_i[sel];
   assign mem_atop_o   = atop_i[sel];
   assign mem_buffer_o = buffer_i[sel];

   assign rdata_o = mem_rdata_i;
   assign busy_o  = (usage != '0) | mem_req_o;

   always_comb begin
      gnt_o    = '0;
      rvalid_o = '0;
      err_o    = '0;
      if (hs) gnt_o[sel] = 1'b1;
      if (pop) begin
         rvalid_o[head] = 1'b1;
         err_o[head]    = mem_err_i;
      end
   end

   always_comb begin
      prio_d     = prio_q;
      lock_d     = lock_q;
      lock_idx_d = lock_idx_q;
      if (hs) prio_d = (sel == IdxW'(NumReq - 1)) ? '0 : sel + 1'b1;
      if (can_issue) begin
         lock_d     = mem_req_o & ~mem_gnt_i;
         lock_idx_d = sel;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         prio_q     <= '0;
         lock_q     <= 1'b0;
         lock_idx_q <= '0;
      end else begin
         prio_q     <= prio_d;
         lock_q     <= lock_d;
         lock_idx_q <= lock_idx_d;
      end
   end

   lsu_arb_id_fifo #(
      .Depth (MaxOutstanding),
      .Width (IdxW)
   ) u_id_fifo (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .push_i  (hs),
      .pop_i   (pop),
      .data_i  (sel),
      .head_o  (head),
      .full_o  (fifo_full),
      .empty_o (fifo_empty),
      .usage_o (usage)
   );

   // A response with nothing outstanding has no owner; it is dropped.
   always @(posedge clk_i) begin
      if (rst_ni) begin
         assert (!(mem_rvalid_i && fifo_empty))
            else $warning("lsu_data_port_arbiter: response with no outstanding request dropped");
      end
   end

endmodule

// File: tb/tb_lsu_data_port_arbiter.sv
module tb_lsu_data_port_arbiter;

   localparam int NR = 4;
   localparam int MO = 2;
   localparam int AW = 32;
   localparam int DW = 32;

   logic clk_i = 1'b0;
   logic rst_ni = 1'b0;
   always #5 clk_i = ~clk_i;

   logic [NR-1:0]            req_i;
   logic [NR-1:0][AW-1:0]    addr_i;
   logic [NR-1:0]            we_i;
   logic [NR-1:0][DW/8-1:0]  be_i;
   logic [NR-1:0][DW-1:0]    wdata_i;
   logic [NR-1:0][5:0]       atop_i;
   logic [NR-1:0]            buffer_i;
   logic [NR-1:0]            gnt_o, rvalid_o, err_o;
   logic [DW-1:0]            rdata_o;
   logic                     mem_req_o, mem_gnt_i, mem_we_o, mem_buffer_o;
   logic [AW-1:0]            mem_addr_o;
   logic [DW/8-1:0]          mem_be_o;
   logic [DW-1:0]            mem_wdata_o, mem_rdata_i;
   logic [5:0]               mem_atop_o;
   logic                     mem_rvalid_i, mem_err_i, busy_o;

   lsu_data_port_arbiter #(
      .NumReq(NR), .MaxOutstanding(MO), .AddrWidth(AW), .DataWidth(DW)
   ) dut (
      .clk_i(clk_i), .rst_ni(rst_ni), .req_i(req_i), .addr_i(addr_i), .we_i(we_i),
      .be_i(be_i), .wdata_i(wdata_i), .atop_i(atop_i), .buffer_i(buffer_i),
      .gnt_o(gnt_o), .rvalid_o(rvalid_o), .rdata_o(rdata_o), .err_o(err_o),
      .mem_req_o(mem_req_o), .mem_gnt_i(mem_gnt_i), .mem_addr_o(mem_addr_o),
      .mem_we_o(mem_we_o), .mem_be_o(mem_be_o), .mem_wdata_o(mem_wdata_o),
      .mem_atop_o(mem_atop_o), .mem_buffer_o(mem_buffer_o),
      .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i), .mem_err_i(mem_err_i),
      .busy_o(busy_o)
   );

   typedef struct {
      int          idx;
      logic [31:0] data;
      logic        err;
   } rsp_t;

   int   exp_gnt_q[$];
   rsp_t exp_rsp_q[$];
   int   n_pass = 0;
   int   n_chk  = 0;
   logic [3:0] we_pat = 4'b0101;

   function automatic logic [31:0] addr_of(input int i);
      return 32'h1000 + 32'(i) * 32'h10;
   endfunction

   function automatic logic [31:0] wdata_of(input int i);
      return 32'hD000_0000 + 32'(i);
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   task automatic exp_rsp(input int idx, input logic [31:0] data, input logic err);
      rsp_t r;
      r.idx = idx; r.data = data; r.err = err;
      exp_rsp_q.push_back(r);
   endtask

   // Scoreboard monitor: consumes an expectation whenever the DUT shows a grant or response.
   int         mon_e;
   rsp_t       mon_r;
   logic [3:0] mon_oh;
   always @(negedge clk_i) begin
      if (gnt_o != '0) begin
         if (exp_gnt_q.size() == 0) chk("gnt_unexpected", 64'(gnt_o), 64'h0);
         else begin
            mon_e  = exp_gnt_q.pop_front();
            mon_oh = 4'b0001 << mon_e;
            chk("gnt_onehot", 64'(gnt_o), 64'(mon_oh));
            chk("mem_addr", 64'(mem_addr_o), 64'(addr_of(mon_e)));
            chk("mem_wdata", 64'(mem_wdata_o), 64'(wdata_of(mon_e)));
            chk("mem_we", 64'(mem_we_o), 64'(we_pat[mon_e]));
         end
      end
      if (rvalid_o != '0) begin
         if (exp_rsp_q.size() == 0) chk("rvalid_unexpected", 64'(rvalid_o), 64'h0);
         else begin
            mon_r  = exp_rsp_q.pop_front();
            mon_oh = 4'b0001 << mon_r.idx;
            chk("rvalid_route", 64'(rvalid_o), 64'(mon_oh));
            chk("rdata", 64'(rdata_o), 64'(mon_r.data));
            chk("err_route", 64'(err_o), mon_r.err ? 64'(mon_oh) : 64'h0);
         end
      end
   end

   task automatic drive(input logic [3:0] rq, input logic g, input logic rv,
                        input logic [31:0] rd, input logic er);
      req_i = rq; mem_gnt_i = g; mem_rvalid_i = rv; mem_rdata_i = rd; mem_err_i = er;
   endtask

   task automatic step();
      @(posedge clk_i);
      #1;
   endtask

   task automatic do_reset();
      drive(4'b0000, 1'b0, 1'b0, 32'h0, 1'b0);
      rst_ni = 1'b0;
      step();
      step();
      rst_ni = 1'b1;
      step();
   endtask

   task automatic phase_end(input string name);
      drive(4'b0000, 1'b0, 1'b0, 32'h0, 1'b0);
      chk({name, "_pending_gnt"}, 64'(exp_gnt_q.size()), 64'h0);
      chk({name, "_pending_rsp"}, 64'(exp_rsp_q.size()), 64'h0);
   endtask

   initial begin
      for (int i = 0; i < NR; i++) begin
         addr_i[i]  = addr_of(i);
         wdata_i[i] = wdata_of(i);
         be_i[i]    = 4'(1 << i);
         atop_i[i]  = 6'(i + 1);
      end
      we_i     = we_pat;
      buffer_i = 4'b1010;
      drive(4'b0000, 1'b0, 1'b0, 32'h0, 1'b0);
      repeat (2) @(posedge clk_i);
      #1;
      chk("rst_mem_req", 64'(mem_req_o), 64'h0);
      chk("rst_gnt", 64'(gnt_o), 64'h0);
      chk("rst_rvalid", 64'(rvalid_o), 64'h0);
      chk("rst_busy", 64'(busy_o), 64'h0);
      rst_ni = 1'b1;
      step();

      // single requester, one transaction per cycle
      do_reset();
      drive(4'b0010, 1'b1, 1'b0, 32'h0, 1'b0); exp_gnt_q.push_back(1); step();
      for (int k = 0; k < 3; k++) begin
         drive(4'b0010, 1'b1, 1'b1, 32'hA0 + 32'(k), 1'b0);
         exp_gnt_q.push_back(1); exp_rsp(1, 32'hA0 + 32'(k), 1'b0);
         step();
      end
      drive(4'b0000, 1'b0, 1'b1, 32'hA3, 1'b0); exp_rsp(1, 32'hA3, 1'b0); step();
      phase_end("single");

      // contention: all four request, pointer wraps
      do_reset();
      drive(4'b1111, 1'b1, 1'b0, 32'h0, 1'b0); exp_gnt_q.push_back(0); step();
      for (int k = 1; k <= 4; k++) begin
         drive(4'b1111, 1'b1, 1'b1, 32'hB0 + 32'(k - 1), 1'b0);
         exp_gnt_q.push_back(k % 4); exp_rsp(k - 1, 32'hB0 + 32'(k - 1), 1'b0);
         step();
      end
      drive(4'b0000, 1'b0, 1'b1, 32'hB4, 1'b0); exp_rsp(0, 32'hB4, 1'b0); step();
      phase_end("contend");

      // lock while stalled
      do_reset();
      for (int k = 0; k < 3; k++) begin
         drive(4'b0001, 1'b0, 1'b0, 32'h0, 1'b0);
         #1;
         chk("stall_req", 64'(mem_req_o), 64'h1);
         chk("stall_addr", 64'(mem_addr_o), 64'(addr_of(0)));
         step();
      end
      drive(4'b1001, 1'b1, 1'b0, 32'h0, 1'b0); exp_gnt_q.push_back(0); step();
      drive(4'b1000, 1'b1, 1'b1, 32'hC0, 1'b0);
      exp_gnt_q.push_back(3); exp_rsp(0, 32'hC0, 1'b0); step();
      drive(4'b0000, 1'b0, 1'b1, 32'hC1, 1'b0); exp_rsp(3, 32'hC1, 1'b0); step();
      drive(4'b0010, 1'b0, 1'b0, 32'h0, 1'b0);
      #1; chk("lock_sel_addr", 64'(mem_addr_o), 64'(addr_of(1)));
      step();
      drive(4'b0011, 1'b0, 1'b0, 32'h0, 1'b0);
      #1; chk("lock_hold_addr", 64'(mem_addr_o), 64'(addr_of(1)));
      step();
      drive(4'b0011, 1'b1, 1'b0, 32'h0, 1'b0); exp_gnt_q.push_back(1); step();
      drive(4'b0001, 1'b1, 1'b1, 32'hC2, 1'b0);
      exp_gnt_q.push_back(0); exp_rsp(1, 32'hC2, 1'b0); step();
      drive(4'b0000, 1'b0, 1'b1, 32'hC3, 1'b0); exp_rsp(0, 32'hC3, 1'b0); step();
      phase_end("lock");

      // back-pressure at MaxOutstanding
      do_reset();
      drive(4'b0001, 1'b1, 1'b0, 32'h0, 1'b0); exp_gnt_q.push_back(0); step();
      drive(4'b0001, 1'b1, 1'b0, 32'h0, 1'b0); exp_gnt_q.push_back(0); step();
      for (int k = 0; k < 2; k++) begin
         drive(4'b0001, 1'b1, 1'b0, 32'h0, 1'b0);
         #1;
         chk("bp_stall_req", 64'(mem_req_o), 64'h0);
         chk("bp_busy", 64'(busy_o), 64'h1);
         step();
      end
      drive(4'b0001, 1'b1, 1'b1, 32'hD0, 1'b0);
      exp_gnt_q.push_back(0); exp_rsp(0, 32'hD0, 1'b0);
      #1; chk("bp_pop_issue", 64'(mem_req_o), 64'h1);
      step();
      drive(4'b0001, 1'b1, 1'b0, 32'h0, 1'b0);
      #1; chk("bp_full_again", 64'(mem_req_o), 64'h0);
      step();
      drive(4'b0000, 1'b0, 1'b1, 32'hD1, 1'b0); exp_rsp(0, 32'hD1, 1'b0); step();
      drive(4'b0000, 1'b0, 1'b1, 32'hD2, 1'b0); exp_rsp(0, 32'hD2, 1'b0); step();
      phase_end("bp");
      chk("bp_idle_busy", 64'(busy_o), 64'h0);

      // response routing with an error on the second response
      do_reset();
      drive(4'b0100, 1'b1, 1'b0, 32'h0, 1'b0); exp_gnt_q.push_back(2); step();
      drive(4'b0001, 1'b1, 1'b0, 32'h0, 1'b0); exp_gnt_q.push_back(0); step();
      drive(4'b0010, 1'b1, 1'b1, 32'hA, 1'b0);
      exp_gnt_q.push_back(1); exp_rsp(2, 32'hA, 1'b0); step();
      drive(4'b0000, 1'b0, 1'b1, 32'hB, 1'b1); exp_rsp(0, 32'hB, 1'b1); step();
      drive(4'b0000, 1'b0, 1'b1, 32'hC, 1'b0); exp_rsp(1, 32'hC, 1'b0); step();
      phase_end("route");

      // reset with transactions outstanding, then a stray response
      do_reset();
      drive(4'b0001, 1'b1, 1'b0, 32'h0, 1'b0); exp_gnt_q.push_back(0); step();
      drive(4'b0001, 1'b1, 1'b0, 32'h0, 1'b0); exp_gnt_q.push_back(0); step();
      drive(4'b0000, 1'b0, 1'b0, 32'h0, 1'b0);
      #1; chk("pre_rst_busy", 64'(busy_o), 64'h1);
      rst_ni = 1'b0;
      #1;
      chk("in_rst_busy", 64'(busy_o), 64'h0);
      chk("in_rst_gnt", 64'(gnt_o), 64'h0);
      step();
      step();
      rst_ni = 1'b1;
      #1;
      chk("post_rst_busy", 64'(busy_o), 64'h0);
      chk("post_rst_gnt", 64'(gnt_o), 64'h0);
      step();
      drive(4'b0000, 1'b0, 1'b1, 32'hEE, 1'b1);
      #1;
      chk("stray_rvalid", 64'(rvalid_o), 64'h0);
      chk("stray_err", 64'(err_o), 64'h0);
      step();
      phase_end("rst_mid");
      step();

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
